mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the Execute stage. It consumes the same selected ALU operands as the integer ALU (`operandA` from ALU input mux 1, `operandB` from ALU input mux 2) and produces a 32-bit result for the EX/MEM register. `busy` drives the hazard unit so the front of the pipeline stalls while an operation is in flight.

---
 rtl/mul_div_pkg.sv | 31 +++
 rtl/mul_div_special_case.sv | 33 +++
 rtl/mul_div_unit.sv | 157 +++++++++++++++
 tb/tb_mul_div_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mul_div_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mul_div_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mul_div_state_t;

    localparam int          MD_ITER       = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = '1;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic is_div_op(input mul_div_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/mul_div_special_case.sv
// Combinational detector for divide-by-zero and signed-overflow divides.
module mul_div_special_case
    import mul_div_pkg::*;
(
    input  mul_div_op_t op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        hit,
    output logic [31:0] value
);

    logic b_zero;
    logic overflow;

    assign b_zero   = (b == 32'd0);
    assign overflow = (op == OP_DIV || op == OP_REM) && (a == INT_MIN) && (b == 32'hFFFF_FFFF);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hit   = 1'b0;
        value = 32'd0;
        if (is_div_op(op)) begin
            if (b_zero) begin
                hit   = 1'b1;
                value = (op == OP_DIV || op == OP_DIVU) ? DIV_BY_ZERO_Q : a;
            end else if (overflow) begin
                hit   = 1'b1;
                value = (op == OP_DIV) ? INT_MIN : 32'd0;
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and
// restoring divide, sign fix-up in a separate cycle, one-cycle done pulse.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      mulDivOp,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    mul_div_state_t state;
    mul_div_op_t    op_q;
    logic [4:0]     cnt;
    logic [31:0]    mag_a;
    logic [31:0]    mag_b;
    logic           neg;
    logic [63:0]    acc;
    logic [32:0]    rem;

    mul_div_op_t op_in;
    logic        sign_a, sign_b;
    logic [31:0] mag_a_in, mag_b_in;
    logic        neg_in;
    logic        accept;
    logic        sc_hit;
    logic [31:0] sc_value;

    assign op_in = mul_div_op_t'(mulDivOp);

    always_comb begin
        sign_a   = operandA[31] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sign_b   = operandB[31] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
        mag_a_in = sign_a ? -operandA : operandA;
        mag_b_in = sign_b ? -operandB : operandB;
        // The remainder follows the dividend; everything else is the product of signs.
        neg_in   = (op_in inside {OP_REM, OP_REMU}) ? sign_a : (sign_a ^ sign_b);
    end

    assign accept = start && !kill && (state == ST_IDLE || state == ST_DONE);

    mul_div_special_case u_special (
        .op    (op_in),
        .a     (operandA),
        .b     (operandB),
        .hit   (sc_hit),
        .value (sc_value)
    );

    // One iteration of each algorithm; the FSM picks which to commit.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic        div_ok;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};
        div_shift = {rem[31:0], acc[31]};
        div_trial = div_shift - {1'b0, mag_b};
        div_ok    = !div_trial[32];
    end

    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] remv;
    logic [31:0] fix_result;

    always_comb begin
        prod = neg ? -acc : acc;
        quot = neg ? -acc[31:0] : acc[31:0];
        remv = neg ? -rem[31:0] : rem[31:0];
        case (op_q)
            OP_MUL:                     fix_result = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[63:32];
            OP_DIV, OP_DIVU:            fix_result = quot;
            default:                    fix_result = remv;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_q   <= OP_MUL;
            cnt    <= 5'd0;
            mag_a  <= 32'd0;
            mag_b  <= 32'd0;
            neg    <= 1'b0;
            acc    <= 64'd0;
            rem    <= 33'd0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        op_q  <= op_in;
                        mag_a <= mag_a_in;
                        mag_b <= mag_b_in;
                        neg   <= neg_in;
                        cnt   <= 5'd0;
                        rem   <= 33'd0;
                        // Dividend or multiplier enters the low word and shifts out from there.
                        acc   <= {32'd0, is_div_op(op_in) ? mag_a_in : mag_b_in};
                        if (sc_hit) begin
                            result <= sc_value;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_CALC;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (kill) begin
                        state <= ST_IDLE;
                        cnt   <= 5'd0;
                    end else begin
                        if (is_div_op(op_q)) begin
                            rem <= div_ok ? div_trial : div_shift;
                            acc <= {acc[63:32], acc[30:0], div_ok};
                        end else begin
                            acc <= mul_next;
                        end
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'(MD_ITER - 1))
                            state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (kill) begin
                        state <= ST_IDLE;
                    end else begin
                        result <= fix_result;
                        state  <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CALC) || (state == ST_FIX);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        kill;
    logic [2:0]  mulDivOp;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    mul_div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .kill     (kill),
        .mulDivOp (mulDivOp),
        .operandA (operandA),
        .operandB (operandB),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents an op for exactly one edge (edge 0), then scrambles the operands.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start    = 1'b1;
        mulDivOp = op;
        operandA = a;
        operandB = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        mulDivOp = 3'b011;
        operandA = 32'h1234_5678;
        operandB = 32'h0BAD_F00D;
    endtask

    // Samples cycles 0,1,... at the falling edge until done; cyc=-1 on timeout.
    task automatic wait_done(output int cyc, output logic [31:0] res, output int busy_cnt);
        cyc      = -1;
        res      = 32'hxxxx_xxxx;
        busy_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                cyc = k;
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({busy, done, result} !== 34'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
        end
        reset = 1'b0;
    endtask

    task automatic test_mul_basic();
        int cyc, bc;
        logic [31:0] r;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done(cyc, r, bc);
        tests++;
        if (cyc !== 33) begin fails++; $display("FAIL mul_done_cycle: got %0d want 33", cyc); end
        tests++;
        if (bc !== 33) begin fails++; $display("FAIL mul_busy_cycles: got %0d want 33", bc); end
        tests++;
        if (r !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mul_result: got %h want ffffffeb", r); end
    endtask

    task automatic test_mul_high();
        logic [2:0]  ops [3] = '{3'b001, 3'b010, 3'b011};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        int cyc, bc;
        logic [31:0] r;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(cyc, r, bc);
            tests++;
            if (cyc !== 33 || r !== exp[i]) begin
                fails++;
                $display("FAIL mulh_%0d: cycle=%0d result=%h, want cycle=33 result=%h", i, cyc, r, exp[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [5] = '{3'b100, 3'b101, 3'b110, 3'b110, 3'b111};
        logic [31:0] as  [5] = '{32'h8000_0000, 32'd5, 32'd7, 32'h8000_0000, 32'd5};
        logic [31:0] bs  [5] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exp [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'd5};
        int cyc, bc;
        logic [31:0] r;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(cyc, r, bc);
            tests++;
            if (cyc !== 0 || bc !== 0 || r !== exp[i]) begin
                fails++;
                $display("FAIL special_%0d: cycle=%0d busy_cycles=%0d result=%h, want 0 0 %h",
                         i, cyc, bc, r, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{3'b110, 3'b100, 3'b111, 3'b101};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd2, 32'd14};
        int cyc, bc;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(cyc, r, bc);
            tests++;
            if (cyc !== 33 || r !== exp[i]) begin
                fails++;
                $display("FAIL div_%0d: cycle=%0d result=%h, want cycle=33 result=%h", i, cyc, r, exp[i]);
            end
        end
    endtask

    task automatic test_kill();
        int cyc, bc, done_seen;
        logic [31:0] r;
        issue(3'b101, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL kill_idle: busy=%b want 0", busy); end
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        tests++;
        if (done_seen !== 0) begin fails++; $display("FAIL kill_no_done: done pulses=%0d want 0", done_seen); end

        // kill outranks start while idle
        @(negedge clk);
        start = 1'b1; kill = 1'b1; mulDivOp = 3'b000; operandA = 32'd2; operandB = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL kill_over_start: busy=%b done=%b want 0 0", busy, done);
        end

        issue(3'b000, 32'd3, 32'd4);
        wait_done(cyc, r, bc);
        tests++;
        if (cyc !== 33 || r !== 32'd12) begin
            fails++;
            $display("FAIL kill_then_mul: cycle=%0d result=%h, want 33 0000000c", cyc, r);
        end
    endtask

    task automatic test_kill_in_done();
        int cyc, bc;
        logic [31:0] r;
        issue(3'b101, 32'd5, 32'd0);
        wait_done(cyc, r, bc);
        tests++;
        if (cyc !== 0 || r !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL kill_done_pulse: cycle=%0d result=%h, want 0 ffffffff", cyc, r);
        end
        // Still in the DONE cycle: try a new accept together with kill.
        start = 1'b1; kill = 1'b1; mulDivOp = 3'b000; operandA = 32'd6; operandB = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL kill_done_block: busy=%b done=%b result=%h, want 0 0 ffffffff", busy, done, result);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        logic [31:0] r;
        issue(3'b101, 32'd9, 32'd3);
        wait_done(cyc, r, bc);
        tests++;
        if (cyc !== 33 || r !== 32'd3) begin
            fails++;
            $display("FAIL b2b_first: cycle=%0d result=%h, want 33 00000003", cyc, r);
        end
        start = 1'b1; mulDivOp = 3'b000; operandA = 32'd2; operandB = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0; operandA = 32'hFFFF_0000; operandB = 32'h0000_FFFF;
        wait_done(cyc, r, bc);
        tests++;
        if (cyc !== 33 || bc !== 33 || r !== 32'd10) begin
            fails++;
            $display("FAIL b2b_second: cycle=%0d busy_cycles=%0d result=%h, want 33 33 0000000a", cyc, bc, r);
        end
    endtask

    task automatic test_reset_mid();
        issue(3'b000, 32'd11, 32'd13);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        kill     = 1'b0;
        mulDivOp = 3'b000;
        operandA = 32'd0;
        operandB = 32'd0;
        test_reset();
        test_mul_basic();
        test_mul_high();
        test_special();
        test_div();
        test_kill();
        test_kill_in_done();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
